// File: rtl/h264_hdr_pkg.sv
// Shared types and range limits for the macroblock-header parser.
package h264_hdr_pkg;

  typedef enum logic [2:0] {
    ID_MBTYPE  = 3'd0,
    ID_PRED4   = 3'd1,
    ID_CHROMA  = 3'd2,
    ID_MVDX    = 3'd3,
    ID_MVDY    = 3'd4,
    ID_CBP     = 3'd5,
    ID_QPDELTA = 3'd6
  } elem_id_t;

  typedef enum logic [3:0] {
    S_IDLE, S_MBTYPE, S_PRED4, S_CHROMA, S_MVDX, S_MVDY, S_CBP, S_QPD, S_ERR
  } state_t;

  localparam int I16_MAX      = 24;
  localparam int P_INTRA_BASE = 5;
  localparam int CHROMA_MAX   = 3;
  localparam int CBP_MAX      = 47;
  localparam int QPD_MIN      = -26;
  localparam int QPD_MAX      = 25;
  localparam int PRED4_COUNT  = 16;

endpackage

// File: rtl/h264_header_parser_if.sv
// Bit-input and element-output handshakes of the header parser.
interface h264_header_parser_if #(parameter int VAL_W = 17);
  import h264_hdr_pkg::*;

  logic                    bit_in;
  logic                    bit_valid;
  logic                    bit_ready;
  logic                    elem_valid;
  logic                    elem_ready;
  elem_id_t                elem_id;
  logic signed [VAL_W-1:0] elem_val;

  modport master (
    input  bit_in, bit_valid, elem_ready,
    output bit_ready, elem_valid, elem_id, elem_val
  );

  modport slave (
    output bit_in, bit_valid, elem_ready,
    input  bit_ready, elem_valid, elem_id, elem_val
  );
endinterface

// File: rtl/h264_expgolomb_dec.sv
// Serial exp-Golomb decoder; done/value/overflow describe the bit consumed this cycle.
module h264_expgolomb_dec #(
  parameter int MAX_LZ = 15,
  parameter int VAL_W  = 17
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    bit_i,
  input  logic                    bit_en_i,
  input  logic                    se_mode_i,
  input  logic                    clear_i,
  output logic                    done_o,
  output logic signed [VAL_W-1:0] value_o,
  output logic                    overflow_o
);
  localparam int CW  = MAX_LZ + 2;
  localparam int LZW = $clog2(MAX_LZ + 1);

  logic              info_phase_q;
  logic [LZW-1:0]    lz_q, rem_q;
  logic [MAX_LZ-1:0] info_q, info_next;
  logic [CW-1:0]     code, half;

  assign info_next = {info_q[MAX_LZ-2:0], bit_i};

  always_comb begin
    done_o     = 1'b0;
    overflow_o = 1'b0;
    if (bit_en_i) begin
      if (info_phase_q)  done_o     = (rem_q == LZW'(1));
      else if (bit_i)    done_o     = (lz_q == '0);
      else               overflow_o = (lz_q == LZW'(MAX_LZ));
    end
  end

  // A prefix-only codeword (single 1) is codeNum 0.
  assign code    = info_phase_q ? ((CW'(1) << lz_q) - CW'(1)) + CW'(info_next) : '0;
  assign half    = code[0] ? (code + CW'(1)) >> 1 : code >> 1;
  assign value_o = !se_mode_i ? VAL_W'(code) :
                   code[0]    ? VAL_W'(half) : -VAL_W'(half);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      info_phase_q <= 1'b0;
      lz_q         <= '0;
      rem_q        <= '0;
      info_q       <= '0;
    end else if (clear_i) begin
      info_phase_q <= 1'b0;
      lz_q         <= '0;
      rem_q        <= '0;
      info_q       <= '0;
    end else if (bit_en_i) begin
      if (info_phase_q) begin
        info_q <= info_next;
        rem_q  <= rem_q - LZW'(1);
        if (rem_q == LZW'(1)) begin
          info_phase_q <= 1'b0;
          lz_q         <= '0;
          info_q       <= '0;
        end
      end else if (bit_i) begin
        if (lz_q != '0) begin
          info_phase_q <= 1'b1;
          rem_q        <= lz_q;
          info_q       <= '0;
        end
      end else if (lz_q != LZW'(MAX_LZ)) begin
        lz_q <= lz_q + LZW'(1);
      end else begin
        lz_q <= '0;
      end
    end
  end
endmodule

// File: rtl/h264_header_parser.sv
// Macroblock-header parser: sequences syntax elements, range-checks them and
// hands them out one at a time over a valid/ready handshake.
module h264_header_parser
  import h264_hdr_pkg::*;
#(
  parameter int MAX_LZ = 15,
  parameter int VAL_W  = 17
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 sintra_i,
  h264_header_parser_if.master bus,
  output logic                 done_o,
  output logic                 error_o
);
  state_t                  state_q, state_d;
  logic                    intra_q, i4_q, elem_valid_q, last_q, done_q, error_q;
  logic [3:0]              pred_cnt_q;
  logic [1:0]              pred_pos_q, pred_rem_q;
  elem_id_t                elem_id_q, id_d;
  logic signed [VAL_W-1:0] elem_val_q, val_d;
  logic                    emit_d, bad_d, last_d;

  logic                    parse_st, bit_ready, consume, start_ok;
  logic                    eg_done, eg_ovf, eg_se;
  logic signed [VAL_W-1:0] eg_val, intra_code;
  logic                    mb_p16, mb_i4, mb_bad, pred_done;
  logic [3:0]              pred_val;

  assign parse_st  = (state_q != S_IDLE) && (state_q != S_ERR);
  assign bit_ready = parse_st && !elem_valid_q;
  assign consume   = bit_ready && bus.bit_valid;
  // done_q blocks START so a start coinciding with DONE waits one IDLE cycle.
  assign start_ok  = start_i && ((state_q == S_IDLE && !done_q) || state_q == S_ERR);
  assign eg_se     = state_q inside {S_MVDX, S_MVDY, S_QPD};

  h264_expgolomb_dec #(.MAX_LZ(MAX_LZ), .VAL_W(VAL_W)) u_eg (
    .clk        (clk),
    .rst        (rst),
    .bit_i      (bus.bit_in),
    .bit_en_i   (consume && state_q != S_PRED4),
    .se_mode_i  (eg_se),
    .clear_i    (start_ok),
    .done_o     (eg_done),
    .value_o    (eg_val),
    .overflow_o (eg_ovf)
  );

  // P-slice intra types are offset by 5 and otherwise match the I-slice table.
  assign intra_code = intra_q ? eg_val : eg_val - VAL_W'(P_INTRA_BASE);
  assign mb_p16     = !intra_q && (eg_val == '0);
  assign mb_i4      = !mb_p16 && (intra_code == '0);
  assign mb_bad     = !mb_p16 && (intra_code[VAL_W-1] || intra_code > VAL_W'(I16_MAX));

  assign pred_done = consume && (state_q == S_PRED4) &&
                     ((pred_pos_q == 2'd0) ? bus.bit_in : (pred_pos_q == 2'd3));
  assign pred_val  = (pred_pos_q == 2'd0) ? 4'b1000 : {1'b0, pred_rem_q, bus.bit_in};

  always_comb begin
    state_d = state_q;
    emit_d  = 1'b0;
    bad_d   = 1'b0;
    last_d  = 1'b0;
    id_d    = ID_MBTYPE;
    val_d   = eg_val;
    if (eg_ovf) begin
      bad_d = 1'b1;
    end else begin
      case (state_q)
        S_MBTYPE: if (eg_done) begin
          bad_d   = mb_bad;
          emit_d  = !mb_bad;
          state_d = mb_p16 ? S_MVDX : (mb_i4 ? S_PRED4 : S_CHROMA);
        end
        S_PRED4: if (pred_done) begin
          emit_d  = 1'b1;
          id_d    = ID_PRED4;
          val_d   = VAL_W'(pred_val);
          state_d = (pred_cnt_q == 4'(PRED4_COUNT - 1)) ? S_CHROMA : S_PRED4;
        end
        S_CHROMA: if (eg_done) begin
          bad_d   = eg_val > VAL_W'(CHROMA_MAX);
          emit_d  = !bad_d;
          id_d    = ID_CHROMA;
          state_d = i4_q ? S_CBP : S_QPD;
        end
        S_MVDX: if (eg_done) begin
          emit_d  = 1'b1;
          id_d    = ID_MVDX;
          state_d = S_MVDY;
        end
        S_MVDY: if (eg_done) begin
          emit_d  = 1'b1;
          id_d    = ID_MVDY;
          state_d = S_CBP;
        end
        S_CBP: if (eg_done) begin
          bad_d   = eg_val > VAL_W'(CBP_MAX);
          emit_d  = !bad_d;
          id_d    = ID_CBP;
          last_d  = (eg_val == '0);
          state_d = last_d ? S_CBP : S_QPD;
        end
        S_QPD: if (eg_done) begin
          bad_d  = (eg_val < VAL_W'(QPD_MIN)) || (eg_val > VAL_W'(QPD_MAX));
          emit_d = !bad_d;
          id_d   = ID_QPDELTA;
          last_d = 1'b1;
        end
        default: ;
      endcase
    end
    if (bad_d) state_d = S_ERR;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      intra_q      <= 1'b0;
      i4_q         <= 1'b0;
      elem_valid_q <= 1'b0;
      last_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      pred_cnt_q   <= '0;
      pred_pos_q   <= '0;
      pred_rem_q   <= '0;
      elem_id_q    <= ID_MBTYPE;
      elem_val_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (start_ok) begin
        state_q    <= S_MBTYPE;
        intra_q    <= sintra_i;
        error_q    <= 1'b0;
        pred_cnt_q <= '0;
        pred_pos_q <= '0;
      end else if (elem_valid_q) begin
        if (bus.elem_ready) begin
          elem_valid_q <= 1'b0;
          if (last_q) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
            last_q  <= 1'b0;
          end
        end
      end else if (consume) begin
        state_q <= state_d;
        if (bad_d) error_q <= 1'b1;
        if (emit_d) begin
          elem_valid_q <= 1'b1;
          elem_id_q    <= id_d;
          elem_val_q   <= val_d;
          last_q       <= last_d;
        end
        if (state_q == S_MBTYPE && emit_d) i4_q <= mb_i4;
        if (state_q == S_PRED4) begin
          if (pred_done) begin
            pred_pos_q <= 2'd0;
            pred_cnt_q <= pred_cnt_q + 4'd1;
          end else begin
            pred_pos_q <= pred_pos_q + 2'd1;
            pred_rem_q <= {pred_rem_q[0], bus.bit_in};
          end
        end
      end
    end
  end

  assign bus.bit_ready  = bit_ready;
  assign bus.elem_valid = elem_valid_q;
  assign bus.elem_id    = elem_id_q;
  assign bus.elem_val   = elem_val_q;
  assign done_o         = done_q;
  assign error_o        = error_q;
endmodule

// File: tb/tb_h264_header_parser.sv
// Directed bench for h264_header_parser with a scoreboard of expected elements.
module tb_h264_header_parser;
  import h264_hdr_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_i = 1'b0;
  logic sintra_i = 1'b0;
  logic done_o, error_o;

  always #5 clk = ~clk;

  h264_header_parser_if #(.VAL_W(17)) bus();

  h264_header_parser #(.MAX_LZ(15), .VAL_W(17)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .sintra_i (sintra_i),
    .bus      (bus),
    .done_o   (done_o),
    .error_o  (error_o)
  );

  typedef struct { int id; int val; } exp_t;
  exp_t expq[$];
  bit   bitq[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic push_bits(input string s);
    for (int i = 0; i < s.len(); i++) begin
      byte c;
      c = s[i];
      if (c == "0") bitq.push_back(1'b0);
      else if (c == "1") bitq.push_back(1'b1);
    end
  endtask

  task automatic push_exp(input int id, input int val);
    exp_t e;
    e.id = id;
    e.val = val;
    expq.push_back(e);
  endtask

  task automatic do_start(input logic s);
    @(posedge clk); #1;
    start_i = 1'b1;
    sintra_i = s;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk({tag, "_done"}, done_cnt - d0, 1);
    @(negedge clk); #1;
    chk({tag, "_sb_empty"}, expq.size(), 0);
    chk({tag, "_idle_ready"}, bus.bit_ready, 0);
  endtask

  task automatic wait_error(input string tag);
    int n;
    n = 0;
    while (!error_o && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk); #1;
    chk({tag, "_error"}, error_o, 1);
    chk({tag, "_ready"}, bus.bit_ready, 0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_bit_ready"}, bus.bit_ready, 0);
    chk({tag, "_elem_valid"}, bus.elem_valid, 0);
    chk({tag, "_elem_id"}, bus.elem_id, 0);
    chk({tag, "_elem_val"}, bus.elem_val, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_error"}, error_o, 0);
  endtask

  task automatic t1_stim();
    push_exp(ID_MBTYPE, 1);
    push_exp(ID_CHROMA, 0);
    push_exp(ID_QPDELTA, -1);
    push_bits("010 1 011");
  endtask

  task automatic t3_stim();
    push_exp(ID_MBTYPE, 0);
    push_exp(ID_MVDX, 2);
    push_exp(ID_MVDY, -2);
    push_exp(ID_CBP, 1);
    push_exp(ID_QPDELTA, 0);
    push_bits("1 00100 00101 010 1");
  endtask

  // Bit feeder: a bit shown while BITREADY is high is taken at the next rising edge.
  always @(negedge clk) begin
    if (bitq.size() > 0) begin
      bus.bit_valid = 1'b1;
      bus.bit_in = bitq[0];
      if (bus.bit_ready) void'(bitq.pop_front());
    end else begin
      bus.bit_valid = 1'b0;
      bus.bit_in = 1'b0;
    end
  end

  // Element monitor: compares each element accepted at the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (done_o) done_cnt++;
      if (bus.elem_valid && bus.elem_ready) begin
        $display("ELEM id=%0d val=%0d", bus.elem_id, bus.elem_val);
        chk("elem_expected", expq.size() > 0, 1);
        if (expq.size() > 0) begin
          exp_t e;
          e = expq.pop_front();
          chk("elem_id", bus.elem_id, e.id);
          chk("elem_val", bus.elem_val, e.val);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.bit_valid = 1'b0;
    bus.bit_in = 1'b0;
    bus.elem_ready = 1'b1;

    // Reset state
    @(negedge clk); #1;
    check_reset("rst_hold");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    check_reset("rst_rel");

    // Test 1: I16x16 with chroma and QP delta
    do_start(1'b1);
    t1_stim();
    wait_done("t1");

    // Test 2: I4x4 with 16 prediction modes, CBP zero
    do_start(1'b1);
    push_exp(ID_MBTYPE, 0);
    push_exp(ID_PRED4, 8);
    push_exp(ID_PRED4, 5);
    for (int i = 0; i < 14; i++) push_exp(ID_PRED4, 8);
    push_exp(ID_CHROMA, 0);
    push_exp(ID_CBP, 0);
    push_bits("1 1 0101");
    for (int i = 0; i < 14; i++) push_bits("1");
    push_bits("1 1");
    wait_done("t2");

    // Test 3: P16x16 with motion vectors
    do_start(1'b0);
    t3_stim();
    wait_done("t3");

    // Test 4: element backpressure at MBTYPE
    bus.elem_ready = 1'b0;
    do_start(1'b0);
    t3_stim();
    n = 0;
    while (!bus.elem_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t4_valid", bus.elem_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("t4_stall_ready", bus.bit_ready, 0);
      chk("t4_stall_id", bus.elem_id, ID_MBTYPE);
      chk("t4_stall_val", bus.elem_val, 0);
      chk("t4_stall_bits", bitq.size(), 14);
    end
    @(posedge clk); #1;
    bus.elem_ready = 1'b1;
    wait_done("t4");

    // Test 5: too many leading zeros, unsupported P type, recovery
    do_start(1'b1);
    push_bits("0000000000000000");
    wait_error("t5_lz");
    chk("t5_lz_bits", bitq.size(), 0);
    do_start(1'b0);
    chk("t5_clear1", error_o, 0);
    push_bits("010");
    wait_error("t5_ptype");
    do_start(1'b1);
    chk("t5_clear2", error_o, 0);
    t1_stim();
    wait_done("t5_t1");

    // Test 6: reset in the middle of MVDX
    do_start(1'b0);
    push_exp(ID_MBTYPE, 0);
    push_bits("1 001");
    n = 0;
    while (bitq.size() > 0 && n < 30) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("t6_pre_sb", expq.size(), 0);
    rst = 1'b1;
    @(negedge clk); #1;
    check_reset("t6_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    check_reset("t6_rel");
    do_start(1'b0);
    t3_stim();
    wait_done("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
